// File: rtl/reloj_hms_param.sv
// reloj_hms_param: single-clock BCD time-of-day core with button set mode, 12/24-hour display and 2 Hz field blink.
// Optional alarm (alarm registers, SET_AMIN/SET_AHOUR states, alarm output) is built when RELOJ_ALARM_EN is defined.

module reloj_hms_param #(
    parameter int CLK_HZ    = 1000000,
    parameter int ALARM_SEC = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set,
    input  logic       inc,
    input  logic       mode12,
    input  logic       al_on,
    output logic [3:0] S0,
    output logic [3:0] S1,
    output logic [3:0] M0,
    output logic [3:0] M1,
    output logic [3:0] H0,
    output logic [1:0] H1,
    output logic       pm,
    output logic       Dots,
    output logic       alarm
);

    localparam int PRE_W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam int QTR   = CLK_HZ / 4;
    localparam int BLK_W = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(CLK_HZ - 1);
    localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(CLK_HZ / 2);
    localparam logic [BLK_W-1:0] BLK_MAX  = BLK_W'(QTR - 1);

`ifdef RELOJ_ALARM_EN
    typedef enum logic [2:0] {RUN, SET_SEC, SET_MIN, SET_HOUR, SET_AMIN, SET_AHOUR} state_t;
`else
    typedef enum logic [1:0] {RUN, SET_SEC, SET_MIN, SET_HOUR} state_t;
`endif

    // Packed BCD: {tens, ones}.
    function automatic logic [6:0] inc_bcd60(input logic [6:0] v);
        if (v == 7'h59)
            return 7'h00;
        else if (v[3:0] == 4'd9)
            return {v[6:4] + 3'd1, 4'd0};
        else
            return {v[6:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [5:0] inc_bcd24(input logic [5:0] v);
        if (v == 6'h23)
            return 6'h00;
        else if (v[3:0] == 4'd9)
            return {v[5:4] + 2'd1, 4'd0};
        else
            return {v[5:4], v[3:0] + 4'd1};
    endfunction

    // Returns {pm, tens[1:0], ones[3:0]} for a 24-hour BCD hour.
    function automatic logic [6:0] hour_disp(input logic [5:0] h_bcd, input logic m12);
        logic [4:0] h;
        logic [4:0] d;
        logic       p;
        h = 5'(h_bcd[5:4]) * 5'd10 + 5'(h_bcd[3:0]);
        d = h;
        p = 1'b0;
        if (m12) begin
            p = (h >= 5'd12);
            if (h == 5'd0)
                d = 5'd12;
            else if (h > 5'd12)
                d = h - 5'd12;
        end
        if (d >= 5'd20)
            return {p, 2'd2, 4'(d - 5'd20)};
        else if (d >= 5'd10)
            return {p, 2'd1, 4'(d - 5'd10)};
        else
            return {p, 2'd0, 4'(d)};
    endfunction

    state_t             state_q, state_d;
    logic [PRE_W-1:0]   pre;
    logic [BLK_W-1:0]   blk_cnt;
    logic               blink;
    logic [6:0]         sec, min;
    logic [5:0]         hr;
    logic               set_q, inc_q, set_ev, inc_ev, armed;
    logic               tick;
    logic [6:0]         sec_t, min_t;
    logic [5:0]         hr_t;

    // Edge events are registered, so a button acts one cycle after its rising edge;
    // armed masks an edge seen in the first cycle out of reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            set_q  <= 1'b0;
            inc_q  <= 1'b0;
            set_ev <= 1'b0;
            inc_ev <= 1'b0;
            armed  <= 1'b0;
        end else begin
            set_q  <= set;
            inc_q  <= inc;
            set_ev <= armed & set & ~set_q;
            inc_ev <= armed & inc & ~inc_q;
            armed  <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        if (set_ev) begin
            case (state_q)
                RUN:       state_d = SET_SEC;
                SET_SEC:   state_d = SET_MIN;
                SET_MIN:   state_d = SET_HOUR;
`ifdef RELOJ_ALARM_EN
                SET_HOUR:  state_d = SET_AMIN;
                SET_AMIN:  state_d = SET_AHOUR;
                SET_AHOUR: state_d = RUN;
`else
                SET_HOUR:  state_d = RUN;
`endif
                default:   state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    // Prescaler only runs while staying in RUN, so the first second after set mode is full length.
    always_ff @(posedge clk) begin
        if (rst)
            pre <= '0;
        else if (state_q == RUN && state_d == RUN)
            pre <= (pre == PRE_MAX) ? '0 : pre + 1'b1;
        else
            pre <= '0;
    end

    assign tick = (state_q == RUN) && (pre == PRE_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt <= '0;
            blink   <= 1'b0;
        end else if (blk_cnt == BLK_MAX) begin
            blk_cnt <= '0;
            blink   <= ~blink;
        end else begin
            blk_cnt <= blk_cnt + 1'b1;
        end
    end

    // Next time-of-day on a tick, with the full carry chain resolved in one cycle.
    always_comb begin
        sec_t = inc_bcd60(sec);
        min_t = min;
        hr_t  = hr;
        if (sec == 7'h59) begin
            min_t = inc_bcd60(min);
            if (min == 7'h59)
                hr_t = inc_bcd24(hr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec <= 7'h00;
            min <= 7'h00;
            hr  <= 6'h00;
        end else if (set_ev) begin
            if (state_q == RUN)
                sec <= 7'h00;
        end else if (inc_ev && state_q != RUN) begin
            case (state_q)
                SET_SEC:  sec <= inc_bcd60(sec);
                SET_MIN:  min <= inc_bcd60(min);
                SET_HOUR: hr  <= inc_bcd24(hr);
                default:  ;
            endcase
        end else if (tick) begin
            sec <= sec_t;
            min <= min_t;
            hr  <= hr_t;
        end
    end

    logic [6:0] src_sec, src_min;
    logic [5:0] src_hr;
    logic [6:0] hdisp;

`ifdef RELOJ_ALARM_EN
    logic [6:0] amin;
    logic [5:0] ahr;
    logic [5:0] al_cnt;
    logic       alarm_q;
    logic       alarm_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            amin <= 7'h00;
            ahr  <= 6'h00;
        end else if (inc_ev && !set_ev) begin
            if (state_q == SET_AMIN)
                amin <= inc_bcd60(amin);
            else if (state_q == SET_AHOUR)
                ahr <= inc_bcd24(ahr);
        end
    end

    assign alarm_hit = tick && al_on && (hr_t == ahr) && (min_t == amin) && (sec_t == 7'h00);

    // Any button edge dismisses the alarm; otherwise it lasts ALARM_SEC ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_q <= 1'b0;
            al_cnt  <= '0;
        end else if (!al_on || set_ev || inc_ev) begin
            alarm_q <= 1'b0;
        end else if (alarm_hit) begin
            alarm_q <= 1'b1;
            al_cnt  <= 6'(ALARM_SEC);
        end else if (tick && alarm_q) begin
            al_cnt <= al_cnt - 6'd1;
            if (al_cnt == 6'd1)
                alarm_q <= 1'b0;
        end
    end

    assign alarm = alarm_q;
`else
    logic [6:0] unused_cfg;
    assign unused_cfg = {al_on, 6'(ALARM_SEC)};
    assign alarm      = 1'b0;
`endif

    always_comb begin
        src_sec = sec;
        src_min = min;
        src_hr  = hr;
`ifdef RELOJ_ALARM_EN
        if (state_q == SET_AMIN || state_q == SET_AHOUR) begin
            src_sec = 7'h00;
            src_min = amin;
            src_hr  = ahr;
        end
`endif
        hdisp = hour_disp(src_hr, mode12);
        S1 = {1'b0, src_sec[6:4]};
        S0 = src_sec[3:0];
        M1 = {1'b0, src_min[6:4]};
        M0 = src_min[3:0];
        H1 = hdisp[5:4];
        H0 = hdisp[3:0];
        pm = hdisp[6];
        if (blink) begin
            case (state_q)
                SET_SEC: begin
                    S1 = 4'hF;
                    S0 = 4'hF;
                end
                SET_MIN: begin
                    M1 = 4'hF;
                    M0 = 4'hF;
                end
                SET_HOUR: begin
                    H1 = 2'b11;
                    H0 = 4'hF;
                end
`ifdef RELOJ_ALARM_EN
                SET_AMIN: begin
                    M1 = 4'hF;
                    M0 = 4'hF;
                end
                SET_AHOUR: begin
                    H1 = 2'b11;
                    H0 = 4'hF;
                end
`endif
                default: ;
            endcase
        end
    end

    assign Dots = (state_q != RUN) || (pre < PRE_HALF);

endmodule

// File: tb/tb_reloj_hms_param.sv
// Scoreboard bench for reloj_hms_param: a seconds-of-day reference model predicts every cycle's display,
// a separate monitor pops and compares. Alarm scenarios are exercised when RELOJ_ALARM_EN is defined.

module tb_reloj_hms_param;
    localparam int CLK_HZ    = 8;
    localparam int ALARM_SEC = 30;
`ifdef RELOJ_ALARM_EN
    localparam int NST = 6;
`else
    localparam int NST = 4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1, set = 1'b0, inc = 1'b0, mode12 = 1'b0, al_on = 1'b0;
    logic [3:0] S0, S1, M0, M1, H0;
    logic [1:0] H1;
    logic       pm, Dots, alarm;

    reloj_hms_param #(.CLK_HZ(CLK_HZ), .ALARM_SEC(ALARM_SEC)) dut (
        .clk(clk), .rst(rst), .set(set), .inc(inc), .mode12(mode12), .al_on(al_on),
        .S0(S0), .S1(S1), .M0(M0), .M1(M1), .H0(H0), .H1(H1),
        .pm(pm), .Dots(Dots), .alarm(alarm)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          stamp;
        logic [21:0] digits;
        logic        pm;
        logic        dots;
        logic        alarm;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc_n = 0;
    int   m12_sel = 0;   // 0/1 forced, 2 random
    int   al_sel  = 0;   // 0/1 forced, 2 mostly-on random

    // Reference model: time as seconds of day, set mode as a field index.
    int m_tod, m_mode, m_pre, m_edges, m_am, m_ah, m_al_left;
    bit m_al, s_prev, i_prev, s_pend, i_pend, armed;

    task automatic check(input string name, input int stamp, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, stamp, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic s, input logic i, input logic a);
        bit tick;
        int nmode, sec, mn, hr;
        if (r) begin
            m_tod = 0; m_mode = 0; m_pre = 0; m_edges = 0; m_am = 0; m_ah = 0;
            m_al = 0; m_al_left = 0; s_prev = 0; i_prev = 0; s_pend = 0; i_pend = 0; armed = 0;
            return;
        end
        tick  = (m_mode == 0) && (m_pre == CLK_HZ - 1);
        nmode = s_pend ? (m_mode + 1) % NST : m_mode;
        sec = m_tod % 60;
        mn  = (m_tod / 60) % 60;
        hr  = m_tod / 3600;
        if (s_pend) begin
            if (m_mode == 0) sec = 0;
        end else if (i_pend) begin
            case (m_mode)
                1: sec  = (sec + 1) % 60;
                2: mn   = (mn + 1) % 60;
                3: hr   = (hr + 1) % 24;
                4: m_am = (m_am + 1) % 60;
                5: m_ah = (m_ah + 1) % 24;
                default: ;
            endcase
        end
        m_tod = hr * 3600 + mn * 60 + sec;
        if (tick && !s_pend) m_tod = (m_tod + 1) % 86400;
`ifdef RELOJ_ALARM_EN
        if (!a || s_pend || i_pend) m_al = 0;
        else if (tick && m_tod == m_ah * 3600 + m_am * 60) begin
            m_al = 1;
            m_al_left = ALARM_SEC;
        end else if (tick && m_al) begin
            m_al_left--;
            if (m_al_left == 0) m_al = 0;
        end
`else
        if (a) m_al = 0;
`endif
        m_pre  = (m_mode == 0 && nmode == 0) ? (m_pre + 1) % CLK_HZ : 0;
        m_mode = nmode;
        m_edges++;
        s_pend = armed && s && !s_prev;
        i_pend = armed && i && !i_prev;
        s_prev = s;
        i_prev = i;
        armed  = 1;
    endtask

    function automatic exp_t make_exp();
        exp_t e;
        int ds, dm, dh, dd;
        bit p, blink;
        logic [3:0] s1, s0, m1, m0, h0;
        logic [1:0] h1;
        ds = m_tod % 60;
        dm = (m_tod / 60) % 60;
        dh = m_tod / 3600;
        if (m_mode >= 4) begin
            ds = 0; dm = m_am; dh = m_ah;
        end
        p  = 0;
        dd = dh;
        if (mode12) begin
            p  = (dh >= 12);
            dd = (dh % 12 == 0) ? 12 : dh % 12;
        end
        s1 = 4'(ds / 10); s0 = 4'(ds % 10);
        m1 = 4'(dm / 10); m0 = 4'(dm % 10);
        h1 = 2'(dd / 10); h0 = 4'(dd % 10);
        blink = ((m_edges / (CLK_HZ / 4)) % 2) == 1;
        if (blink) begin
            if (m_mode == 1) begin s1 = 4'hF; s0 = 4'hF; end
            if (m_mode == 2 || m_mode == 4) begin m1 = 4'hF; m0 = 4'hF; end
            if (m_mode == 3 || m_mode == 5) begin h1 = 2'b11; h0 = 4'hF; end
        end
        e.stamp  = 0;
        e.digits = {s1, s0, m1, m0, h1, h0};
        e.pm     = p;
        e.dots   = (m_mode != 0) || (m_pre < CLK_HZ / 2);
        e.alarm  = m_al;
        return e;
    endfunction

    task automatic cyc(input logic r, input logic s, input logic i);
        exp_t e;
        #3;
        rst = r; set = s; inc = i;
        mode12 = (m12_sel == 2) ? 1'($urandom_range(0, 1)) : m12_sel[0];
        al_on  = (al_sel == 2) ? ($urandom_range(0, 15) != 0) : al_sel[0];
        @(posedge clk);
        model_edge(r, s, i, al_on);
        @(negedge clk);
        cyc_n++;
        e = make_exp();
        e.stamp = cyc_n;
        sb.push_back(e);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic press(input logic s, input logic i);
        cyc(1'b0, s, i);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_to(input int h, input int m, input int s);
        int n;
        press(1'b1, 1'b0);
        for (int k = 0; k < s; k++) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        n = (m - (m_tod / 60) % 60 + 60) % 60;
        for (int k = 0; k < n; k++) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        n = (h - m_tod / 3600 + 24) % 24;
        for (int k = 0; k < n; k++) press(1'b0, 1'b1);
        while (m_mode != 0) press(1'b1, 1'b0);
    endtask

`ifdef RELOJ_ALARM_EN
    task automatic set_alarm(input int h, input int m);
        int n;
        while (m_mode != 4) press(1'b1, 1'b0);
        n = (m - m_am + 60) % 60;
        for (int k = 0; k < n; k++) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        n = (h - m_ah + 24) % 24;
        for (int k = 0; k < n; k++) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
    endtask
`endif

    // Monitor: compares every expectation the driver has queued for the current cycle.
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check("digits", e.stamp, 32'({S1, S0, M1, M0, H1, H0}), 32'(e.digits));
            check("pm",     e.stamp, 32'(pm),    32'(e.pm));
            check("dots",   e.stamp, 32'(Dots),  32'(e.dots));
            check("alarm",  e.stamp, 32'(alarm), 32'(e.alarm));
        end
    end

    initial begin
        int waited;
        // Reset, then one minute of free running.
        m12_sel = 0; al_sel = 0;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        run(CLK_HZ * 60);
        m12_sel = 2; al_sel = 2;
        run(CLK_HZ * 3);

        // Preload 23:59:59 and roll over to midnight in 12-hour display.
        set_to(23, 59, 59);
        m12_sel = 1;
        run(CLK_HZ * 2);

        // SET_MIN wrap at 59 without carry into hours.
        m12_sel = 0;
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        for (int k = 0; k < 59; k++) press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        run(6);
        while (m_mode != 0) press(1'b1, 1'b0);
        run(CLK_HZ + 3);

        // Simultaneous set and inc in RUN: set wins.
        press(1'b1, 1'b1);
        run(5);
        while (m_mode != 0) press(1'b1, 1'b0);
        run(CLK_HZ);

        // 13:xx with the display mode toggling.
        set_to(13, 5, 0);
        for (int k = 0; k < 8; k++) begin
            m12_sel = k % 2;
            run(5);
        end

        // Reset in the middle of set mode.
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        m12_sel = 2;
        run(CLK_HZ * 2);

        // Randomized button and mode activity.
        for (int k = 0; k < 3000; k++)
            cyc(1'b0, $urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0);
        while (m_mode != 0) press(1'b1, 1'b0);
        run(CLK_HZ);

`ifdef RELOJ_ALARM_EN
        // Alarm at 00:01 runs its full duration, then a repeat dismissed by inc.
        m12_sel = 0; al_sel = 1;
        cyc(1'b1, 1'b0, 1'b0);
        set_alarm(0, 1);
        run(CLK_HZ * 60 + CLK_HZ * ALARM_SEC + 2 * CLK_HZ);
        cyc(1'b1, 1'b0, 1'b0);
        set_alarm(0, 1);
        run(CLK_HZ * 60 + 5 * CLK_HZ);
        press(1'b0, 1'b1);
        run(3 * CLK_HZ);
`endif

        waited = 0;
        while (sb.size() > 0 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        #3;
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reloj_hms_param.md
# reloj_hms_param

Parametrised single-clock-domain time-of-day core: seconds, minutes and hours as BCD digits, with a button-driven set mode and runtime 12/24-hour display selection. It replaces ripple-clocked counter chains with one prescaler that generates clock-enable pulses, so every register runs on `clk`. It sits between the board clock, the debounced button synchronisers and the 7-segment display multiplexer.

## Interface
- `CLK_HZ`, default 1000000: `clk` frequency. Must be a multiple of 4 and ≥ 4.
- `ALARM_SEC`, default 30: alarm duration in seconds, range 1..59. Used only with `RELOJ_ALARM_EN`.
- `clk`, in, 1: master clock. This is the block's only clock.
- `rst`, in, 1: reset. Synchronous and active-high.
- `set`, in, 1: field-select button, already synchronised. Acts on its rising edge.
- `inc`, in, 1: increment button, already synchronised. Acts on its rising edge.
- `mode12`, in, 1: display mode. 1 = 12-hour display, 0 = 24-hour display.
- `al_on`, in, 1: alarm enable.
- `S0`, `S1`, `M0`, `M1`, `H0`, out, 4 each: BCD digits for seconds, minutes and hours.
- `H1`, out, 2: BCD hour tens digit.
- `pm`, out, 1: PM indicator. Valid only in 12-hour display.
- `Dots`, out, 1: 1 Hz colon.
- `alarm`, out, 1: alarm active.

## Operation
- **Prescaler.** Counter `pre` counts 0..CLK_HZ-1 and wraps. `tick` is true when `pre == CLK_HZ-1` in state RUN. In every set state `pre` is held at 0.
- **Time registers.** Time is always stored in 24-hour BCD: sec 00..59, min 00..59, hr 00..23. On `tick`, sec increments. Carries cascade in the same cycle: 59→00 sec carries to min, 59→00 min carries to hr, 23→00 hr wraps.
- **Buttons.** Rising edges are detected internally with one-cycle registers. An edge present in the cycle reset deasserts is ignored.
- **Set FSM.** States: RUN → SET_SEC → SET_MIN → SET_HOUR → RUN. With `RELOJ_ALARM_EN`, SET_HOUR → SET_AMIN → SET_AHOUR → RUN. Each `set` edge advances one state.
- **Entering SET_SEC.** sec is cleared to 00.
- **`inc` edge in a set state.** Increments only the selected field and wraps it: sec or min 59→00, hr 23→00. No carry into the next field. An `inc` edge in RUN is ignored, except for alarm dismissal (see Configuration).
- **Simultaneous edges.** If `set` and `inc` edges arrive in the same cycle, `set` wins and `inc` is dropped.
- **Display conversion.** With `mode12` = 1: hr 0 displays 12 with `pm` = 0; hr 1..11 displays as is with `pm` = 0; hr 12 displays 12 with `pm` = 1; hr 13..23 displays hr-12 with `pm` = 1. With `mode12` = 0, the display equals hr and `pm` = 0. `mode12` may change at any time and affects display only.
- **Blink.** A free-running counter toggles `blink` every CLK_HZ/4 cycles, giving a 2 Hz square wave. While `blink` = 1, the digits of the selected field are forced to 4'b1111 (`H1` to 2'b11).
- **Dots.** In RUN, `Dots` = 1 while `pre` < CLK_HZ/2. In all set states, `Dots` = 1.
- **Reset values.** All time registers 00:00:00; alarm registers 00:00; FSM in RUN; `pre` = 0; `blink` = 0; button edge registers 0.
- **Reset outputs.** All digit outputs 0, `pm` = 0, `Dots` = 1, `alarm` = 0.

## Timing
- Time registers update on the `clk` edge where `tick` = 1. Outputs are combinational from registers, so they show the new value in the cycle after `tick`.
- A button edge takes effect 1 cycle after the input rises: the registered edge acts on the next edge.
- One second lasts exactly CLK_HZ cycles. The first `tick` after reset or after returning to RUN occurs CLK_HZ cycles later.
- `rst` asserted in any state, including mid-set, restores all reset values on the next edge.

## Configuration
- **Macro `RELOJ_ALARM_EN` defined:**
  - Alarm registers amin and ahr are added, set via SET_AMIN and SET_AHOUR. In those states the digits show the alarm value with `S1`/`S0` = 0.
  - `alarm` rises when `al_on` = 1, FSM = RUN and a `tick` makes hr:min:sec equal ahr:amin:00. It stays high for ALARM_SEC ticks.
  - `alarm` clears early on `al_on` = 0, on any `set` or `inc` edge, or on `rst`.
- **Macro undefined:** no alarm registers and no extra states. `alarm` is tied to 0 and `al_on` is ignored.

## Test plan
- CLK_HZ = 8, reset, then 8×60 cycles → `M0` = 1, `S0` = 0, `S1` = 0; `Dots` high for 4 cycles and low for 4 cycles each second.
- Preload 23:59:59 via set mode, run 8 cycles → 00:00:00; in 12-hour mode → `H1` = 1, `H0` = 2, `pm` = 0.
- In SET_MIN at 59, send one `inc` → `M1M0` = 00 and hours unchanged; with `blink` = 1 → `M0` = `M1` = 4'hF.
- `set` and `inc` rise in the same cycle in RUN → FSM = SET_SEC and sec = 00; `inc` has no further effect.
- Hr = 13 with `mode12` = 1 → `H1` = 0, `H0` = 1, `pm` = 1; toggle `mode12` → `H1` = 1, `H0` = 3, `pm` = 0.
- `RELOJ_ALARM_EN`, alarm 00:01, `al_on` = 1, from reset run 8×60 cycles → `alarm` high for 30×8 cycles; a repeat run with an `inc` edge during the alarm → `alarm` cleared the cycle after the edge.
